dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory instance (16-bit words, byte addresses, 1-cycle synchronous read, synchronous write).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Grants one access per cycle using round-robin priority, with an optional requester lock for atomic multi-cycle sequences.
- Routes the registered read data back to the requester that issued the read, with a valid strobe.

Parameters:
- WORD_WIDTH, 16, data word width in bits.
- ADDR_WIDTH, 12, byte-address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_req0  in  1  port 0 access request.
- in_we0  in  1  port 0 write enable (0 = read).
- in_lock0  in  1  port 0 holds ownership after its current grant.
- in_addr0  in  ADDR_WIDTH  port 0 byte address.
- in_wdata0  in  WORD_WIDTH  port 0 write data.
- out_gnt0  out  1  port 0 request accepted this cycle.
- out_rvalid0  out  1  out_rdata0 valid for a read granted last cycle.
- out_rdata0  out  WORD_WIDTH  port 0 read data.
- in_req1, in_we1, in_lock1, in_addr1, in_wdata1, out_gnt1, out_rvalid1, out_rdata1: same as port 0, for port 1.
- out_mem_addr_rd  out  ADDR_WIDTH  to memory read address.
- out_mem_addr_wr  out  ADDR_WIDTH  to memory write address.
- out_mem_word  out  WORD_WIDTH  to memory write data.
- out_mem_write_en  out  1  to memory write enable.
- in_mem_word  in  WORD_WIDTH  from memory read data (valid one cycle after the address is presented).

Behaviour:
- Reset (async assert, sync release):
  - state = FREE; rr_last = 1, so port 0 wins the first conflict.
  - rd_owner_valid = 0.
  - All out_gnt*, out_rvalid* and out_mem_write_en = 0.
- Grant logic is combinational in the current cycle; gnt is high in the same cycle as the accepted req. Requesters hold req/addr/we/wdata stable until gnt.
- States:
  - FREE:
    - Only one req: grant it.
    - Both req: grant the port not equal to rr_last.
    - On grant, rr_last <= granted port.
    - If the granted port has lock=1, go to OWN0 or OWN1.
  - OWNn:
    - Only port n is grantable; the other port's req is stalled (gnt=0).
    - Port n gets gnt whenever req_n=1.
    - Leave to FREE on the first cycle with lock_n=0. That cycle's request is still granted if req_n=1, and rr_last <= n.
    - lock_n=1 with req_n=0 keeps ownership (idle hold).
- Memory drive:
  - out_mem_addr_rd and out_mem_addr_wr = granted addr.
  - out_mem_word = granted wdata.
  - out_mem_write_en = gnt & we of the granted port.
  - With no grant, the addresses hold the port-0 value and write_en = 0.
- Read return:
  - A granted read sets rd_owner_valid <= 1 and rd_owner <= port.
  - Next cycle, out_rvalid[rd_owner] = 1 and out_rdata[rd_owner] = in_mem_word; the other port's rdata = 0.
  - Back-to-back reads every cycle are supported; throughput is 1 access per cycle.
- Write followed by a read of the same address on the next cycle returns the new data (memory write is registered before the read sample).
- Simultaneous read and write from different ports in one cycle are never issued; one grant per cycle.
- Reset mid-operation: a pending rvalid is dropped; lock ownership is cleared.
- Addresses pass through unmodified; the memory ignores byte-lane LSBs.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds:
  - out_stall_cnt0 and out_stall_cnt1 (16 bits each): increment each cycle req_n=1 and gnt_n=0.
  - out_gnt_cnt (16 bits): increments on any grant.
  - All counters saturate at 16'hFFFF, reset to 0, and clear synchronously on in_stats_clr.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - WORD_WIDTH/ADDR_WIDTH defaults.
  - State encoding FREE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - Port-index constants PORT_CPU=0, PORT_DBG=1.
- One natural sub-module: dmem_arb_rr, the 2-way round-robin picker (req0, req1, rr_last -> grant index, any_grant).
- Lock FSM, mux and read-return pipe stay in the top module.

Test Plan:
- Reset, then req0 only, read addr 12'h010 (mem holds 16'hBEEF) -> gnt0 in cycle 0; rvalid0=1 and rdata0=16'hBEEF in cycle 1; rvalid1=0.
- req0 and req1 held for 4 cycles, both reading -> grants alternate 0,1,0,1; each rvalid follows its grant by 1 cycle with the matching data.
- Port 1 locks (lock1=1) for 3 writes to 12'h020/022/024 while req0 is held -> gnt0=0 throughout; memory is written with the 3 words; on lock1=0, port 0 is granted the next cycle.
- Port 0 writes 16'h1234 to 12'h040, then port 1 reads 12'h040 next cycle -> rdata1=16'h1234.
- Assert reset_n=0 in the cycle after a granted read -> rvalid0 low immediately; state returns to FREE; the first conflict after reset is granted to port 0.
- With DMEM_ARB_STATS_EN: hold req1 during port-0 lock for 5 cycles -> stall_cnt1=5; stats_clr -> 0; forced 70000-cycle stall -> stall_cnt1 reads 16'hFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: width defaults, lock-FSM
// state encoding, port indices and a saturating-increment helper used by the
// optional statistics counters (DMEM_ARB_STATS_EN).
package dmem_pkg;

  localparam int WORD_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int STAT_WIDTH     = 16;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
    return (value == {STAT_WIDTH{1'b1}}) ? value : value + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker: with both ports requesting, the port that did
// not win last time is chosen; a lone requester always wins.
module dmem_arb_rr
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic grant_idx,
  output logic any_grant
);

  // Pick the winner for this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_idx = PORT_CPU;
    any_grant = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~rr_last;
    end else if (req1) begin
      grant_idx = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one synchronous data memory between the CPU load/store unit
// (port 0) and the debug/DMA loader (port 1). One access per cycle, granted
// combinationally, round-robin on conflict, with a per-port lock that keeps
// ownership across multi-cycle atomic sequences. Read data returns one cycle
// after the grant on the port that issued the read.
// Optional build macro DMEM_ARB_STATS_EN adds saturating stall/grant counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
`ifdef DMEM_ARB_STATS_EN
  input  logic                  in_stats_clr,
  output logic [STAT_WIDTH-1:0] out_stall_cnt0,
  output logic [STAT_WIDTH-1:0] out_stall_cnt1,
  output logic [STAT_WIDTH-1:0] out_gnt_cnt,
`endif
  input  logic                  in_req0,
  input  logic                  in_we0,
  input  logic                  in_lock0,
  input  logic [ADDR_WIDTH-1:0] in_addr0,
  input  logic [WORD_WIDTH-1:0] in_wdata0,
  output logic                  out_gnt0,
  output logic                  out_rvalid0,
  output logic [WORD_WIDTH-1:0] out_rdata0,
  input  logic                  in_req1,
  input  logic                  in_we1,
  input  logic                  in_lock1,
  input  logic [ADDR_WIDTH-1:0] in_addr1,
  input  logic [WORD_WIDTH-1:0] in_wdata1,
  output logic                  out_gnt1,
  output logic                  out_rvalid1,
  output logic [WORD_WIDTH-1:0] out_rdata1,
  output logic [ADDR_WIDTH-1:0] out_mem_addr_rd,
  output logic [ADDR_WIDTH-1:0] out_mem_addr_wr,
  output logic [WORD_WIDTH-1:0] out_mem_word,
  output logic                  out_mem_write_en,
  input  logic [WORD_WIDTH-1:0] in_mem_word
);

  arb_state_e state;
  logic       rr_last;
  logic       rd_owner_valid;
  logic       rd_owner;

  logic       rr_idx;
  logic       rr_any;
  logic       gnt0;
  logic       gnt1;
  logic       any_gnt;
  logic       gnt_idx;
  logic       gnt_we;
  logic       gnt_lock;

  dmem_arb_rr u_rr (
    .req0      (in_req0),
    .req1      (in_req1),
    .rr_last   (rr_last),
    .grant_idx (rr_idx),
    .any_grant (rr_any)
  );

  // Grant decision: the owner alone while locked, round-robin otherwise.
  // Grants are masked while reset is asserted so nothing reaches the memory.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      OWN0:    gnt0 = in_req0;
      OWN1:    gnt1 = in_req1;
      default: begin
        gnt0 = rr_any && (rr_idx == PORT_CPU);
        gnt1 = rr_any && (rr_idx == PORT_DBG);
      end
    endcase
    gnt0 = gnt0 & reset_n;
    gnt1 = gnt1 & reset_n;
  end

  assign any_gnt  = gnt0 | gnt1;
  assign gnt_idx  = gnt1 ? PORT_DBG : PORT_CPU;
  assign gnt_we   = gnt1 ? in_we1 : in_we0;
  assign gnt_lock = gnt1 ? in_lock1 : in_lock0;

  assign out_gnt0 = gnt0;
  assign out_gnt1 = gnt1;

  // Memory side: the granted port's request, port 0's address when idle.
  assign out_mem_addr_rd  = gnt1 ? in_addr1 : in_addr0;
  assign out_mem_addr_wr  = gnt1 ? in_addr1 : in_addr0;
  assign out_mem_word     = gnt1 ? in_wdata1 : in_wdata0;
  assign out_mem_write_en = any_gnt & gnt_we;

  // Lock FSM and round-robin history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FREE;
      rr_last <= PORT_DBG;
    end else begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      case (state)
        FREE: begin
          if (any_gnt) begin
            rr_last <= gnt_idx;
            if (gnt_lock) begin
              state <= (gnt_idx == PORT_DBG) ? OWN1 : OWN0;
            end
          end
        end
        OWN0: begin
          if (!in_lock0) begin
            state   <= FREE;
            rr_last <= PORT_CPU;
          end
        end
        OWN1: begin
          if (!in_lock1) begin
            state   <= FREE;
            rr_last <= PORT_DBG;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  // Remember who issued the read so next cycle's memory data goes back to it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_owner_valid <= 1'b0;
      rd_owner       <= PORT_CPU;
    end else begin
      rd_owner_valid <= any_gnt & ~gnt_we;
      if (any_gnt && !gnt_we) begin
        rd_owner <= gnt_idx;
      end
    end
  end

  assign out_rvalid0 = rd_owner_valid && (rd_owner == PORT_CPU);
  assign out_rvalid1 = rd_owner_valid && (rd_owner == PORT_DBG);
  assign out_rdata0  = out_rvalid0 ? in_mem_word : '0;
  assign out_rdata1  = out_rvalid1 ? in_mem_word : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cnt0;
  logic [STAT_WIDTH-1:0] stall_cnt1;
  logic [STAT_WIDTH-1:0] gnt_cnt;

  // Saturating stall and grant counters with synchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
      gnt_cnt    <= '0;
    end else if (in_stats_clr) begin
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
      gnt_cnt    <= '0;
    end else begin
      if (in_req0 && !gnt0) stall_cnt0 <= sat_inc(stall_cnt0);
      if (in_req1 && !gnt1) stall_cnt1 <= sat_inc(stall_cnt1);
      if (any_gnt)          gnt_cnt    <= sat_inc(gnt_cnt);
    end
  end

  assign out_stall_cnt0 = stall_cnt0;
  assign out_stall_cnt1 = stall_cnt1;
  assign out_gnt_cnt    = gnt_cnt;
`else
  // Statistics hardware is not built in this configuration.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a directed grant table, hand-written
// multi-cycle sequences, and randomized traffic compared against a
// transaction-level model (owner/last-winner bookkeeping plus a shadow memory).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 12;
  localparam int WW = 16;
  localparam int NWORDS = 2048;

  typedef struct {
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
  } port_in_t;

  typedef struct {
    logic r0, r1, l0, l1;
    logic eg0, eg1;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_req0, in_we0, in_lock0, in_req1, in_we1, in_lock1;
  logic [AW-1:0] in_addr0, in_addr1;
  logic [WW-1:0] in_wdata0, in_wdata1;
  logic          out_gnt0, out_gnt1, out_rvalid0, out_rvalid1;
  logic [WW-1:0] out_rdata0, out_rdata1;
  logic [AW-1:0] out_mem_addr_rd, out_mem_addr_wr;
  logic [WW-1:0] out_mem_word;
  logic          out_mem_write_en;
  logic [WW-1:0] in_mem_word;
`ifdef DMEM_ARB_STATS_EN
  logic          in_stats_clr;
  logic [15:0]   out_stall_cnt0, out_stall_cnt1, out_gnt_cnt;
`endif

  int checks;
  int failures;

  // Model state: current lock owner (-1 none), last winner, shadow memory,
  // and the read whose data should appear this cycle.
  int            m_owner;
  int            m_last;
  logic [WW-1:0] shadow [NWORDS];
  logic          m_pv;
  int            m_pp;
  logic [WW-1:0] m_pd;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
`ifdef DMEM_ARB_STATS_EN
    .in_stats_clr     (in_stats_clr),
    .out_stall_cnt0   (out_stall_cnt0),
    .out_stall_cnt1   (out_stall_cnt1),
    .out_gnt_cnt      (out_gnt_cnt),
`endif
    .in_req0          (in_req0),
    .in_we0           (in_we0),
    .in_lock0         (in_lock0),
    .in_addr0         (in_addr0),
    .in_wdata0        (in_wdata0),
    .out_gnt0         (out_gnt0),
    .out_rvalid0      (out_rvalid0),
    .out_rdata0       (out_rdata0),
    .in_req1          (in_req1),
    .in_we1           (in_we1),
    .in_lock1         (in_lock1),
    .in_addr1         (in_addr1),
    .in_wdata1        (in_wdata1),
    .out_gnt1         (out_gnt1),
    .out_rvalid1      (out_rvalid1),
    .out_rdata1       (out_rdata1),
    .out_mem_addr_rd  (out_mem_addr_rd),
    .out_mem_addr_wr  (out_mem_addr_wr),
    .out_mem_word     (out_mem_word),
    .out_mem_write_en (out_mem_write_en),
    .in_mem_word      (in_mem_word)
  );

  // Synchronous memory: registered write, one-cycle registered read.
  logic [WW-1:0] mem [NWORDS];
  always @(posedge clock) begin
    if (out_mem_write_en) mem[out_mem_addr_wr[AW-1:1]] <= out_mem_word;
    in_mem_word <= mem[out_mem_addr_rd[AW-1:1]];
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic port_in_t mk(input logic req, input logic we, input logic lock,
                                  input logic [AW-1:0] addr, input logic [WW-1:0] wdata);
    port_in_t p;
    p.req = req; p.we = we; p.lock = lock; p.addr = addr; p.wdata = wdata;
    return p;
  endfunction

  task automatic drive(input port_in_t p0, input port_in_t p1);
    in_req0 = p0.req; in_we0 = p0.we; in_lock0 = p0.lock; in_addr0 = p0.addr; in_wdata0 = p0.wdata;
    in_req1 = p1.req; in_we1 = p1.we; in_lock1 = p1.lock; in_addr1 = p1.addr; in_wdata1 = p1.wdata;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_pv    = 1'b0;
    m_pp    = 0;
    m_pd    = '0;
  endtask

  // Holds reset for two cycles with idle inputs; releases it on a falling edge.
  task automatic do_reset();
    drive(mk(0, 0, 0, '0, '0), mk(0, 0, 0, '0, '0));
    reset_n = 1'b0;
    #1;
    check("rst_gnt0", out_gnt0, 0);
    check("rst_gnt1", out_gnt1, 0);
    check("rst_rvalid0", out_rvalid0, 0);
    check("rst_rvalid1", out_rvalid1, 0);
    check("rst_we", out_mem_write_en, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One arbitration cycle, entered and left on a falling edge. Checks grants,
  // memory drive and read return against the model, then advances the model.
  task automatic step(input port_in_t p0, input port_in_t p1, output logic g0, output logic g1);
    port_in_t p[2];
    logic eg[2];
    int w;
    logic granted;
    p[0] = p0; p[1] = p1;
    drive(p0, p1);
    #1;
    eg[0] = 1'b0; eg[1] = 1'b0;
    if (m_owner >= 0)          eg[m_owner] = p[m_owner].req;
    else if (p0.req && p1.req) eg[1 - m_last] = 1'b1;
    else begin eg[0] = p0.req; eg[1] = p1.req; end
    granted = eg[0] | eg[1];
    w = eg[1] ? 1 : 0;

    check("gnt0", out_gnt0, eg[0]);
    check("gnt1", out_gnt1, eg[1]);
    check("rvalid0", out_rvalid0, m_pv && m_pp == 0);
    check("rvalid1", out_rvalid1, m_pv && m_pp == 1);
    check("rdata0", out_rdata0, (m_pv && m_pp == 0) ? m_pd : '0);
    check("rdata1", out_rdata1, (m_pv && m_pp == 1) ? m_pd : '0);
    check("mem_addr_rd", out_mem_addr_rd, granted ? p[w].addr : p0.addr);
    check("mem_we", out_mem_write_en, granted && p[w].we);
    if (granted) check("mem_addr_wr", out_mem_addr_wr, p[w].addr);
    if (granted && p[w].we) check("mem_word", out_mem_word, p[w].wdata);
    g0 = out_gnt0;
    g1 = out_gnt1;

    m_pv = granted && !p[w].we;
    m_pp = w;
    m_pd = shadow[p[w].addr[AW-1:1]];
    if (granted && p[w].we) shadow[p[w].addr[AW-1:1]] = p[w].wdata;
    if (granted) m_last = w;
    if (m_owner >= 0) begin
      if (!p[m_owner].lock) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (granted && p[w].lock) begin
      m_owner = w;
    end
    @(negedge clock);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t     vecs[17];
    port_in_t cur[2];
    logic     g0, g1;
    logic     seq[4];

    checks = 0;
    failures = 0;
    for (int i = 0; i < NWORDS; i++) begin
      mem[i]    <= 16'(i * 37 + 5);
      shadow[i] = 16'(i * 37 + 5);
    end
    mem[12'h010 >> 1]    <= 16'hBEEF;
    shadow[12'h010 >> 1] = 16'hBEEF;
`ifdef DMEM_ARB_STATS_EN
    in_stats_clr = 1'b0;
`endif

    // {req0, req1, lock0, lock1, expected gnt0, expected gnt1}, all reads
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(mk(vecs[i].r0, 0, vecs[i].l0, 12'(12'h100 + i * 4), '0),
           mk(vecs[i].r1, 0, vecs[i].l1, 12'(12'h200 + i * 4), '0), g0, g1);
      check($sformatf("vec%0d_gnt0", i), g0, vecs[i].eg0);
      check($sformatf("vec%0d_gnt1", i), g1, vecs[i].eg1);
    end

    // Single read of a preloaded word.
    do_reset();
    step(mk(1, 0, 0, 12'h010, '0), mk(0, 0, 0, '0, '0), g0, g1);
    check("single_gnt0", g0, 1);
    check("single_rvalid0", out_rvalid0, 1);
    check("single_rdata0", out_rdata0, 16'hBEEF);
    check("single_rvalid1", out_rvalid1, 0);

    // Both ports held reading: grants alternate starting with port 0.
    do_reset();
    cur[0] = mk(1, 0, 0, 12'h010, '0);
    cur[1] = mk(1, 0, 0, 12'h030, '0);
    for (int k = 0; k < 4; k++) begin
      step(cur[0], cur[1], g0, g1);
      seq[k] = g1;
      if (g0) cur[0].addr = cur[0].addr + 12'h2;
      if (g1) cur[1].addr = cur[1].addr + 12'h2;
    end
    check("alt_0", seq[0], 0);
    check("alt_1", seq[1], 1);
    check("alt_2", seq[2], 0);
    check("alt_3", seq[3], 1);

    // Port 1 locks for three writes while port 0 waits.
    do_reset();
    step(mk(0, 0, 0, 12'h050, '0), mk(1, 1, 1, 12'h020, 16'hA001), g0, g1);
    check("lock_w1", g1, 1);
    step(mk(1, 0, 0, 12'h050, '0), mk(1, 1, 1, 12'h022, 16'hA002), g0, g1);
    check("lock_stall_a", g0, 0);
    step(mk(1, 0, 0, 12'h050, '0), mk(1, 1, 0, 12'h024, 16'hA003), g0, g1);
    check("lock_stall_b", g0, 0);
    check("lock_w3", g1, 1);
    step(mk(1, 0, 0, 12'h050, '0), mk(0, 0, 0, '0, '0), g0, g1);
    check("lock_release_gnt0", g0, 1);
    check("lock_mem_020", mem[12'h020 >> 1], 16'hA001);
    check("lock_mem_022", mem[12'h022 >> 1], 16'hA002);
    check("lock_mem_024", mem[12'h024 >> 1], 16'hA003);

    // Write by port 0 then read-back by port 1 on the next cycle.
    step(mk(1, 1, 0, 12'h040, 16'h1234), mk(0, 0, 0, '0, '0), g0, g1);
    step(mk(0, 0, 0, '0, '0), mk(1, 0, 0, 12'h040, '0), g0, g1);
    check("wr_rd_rvalid1", out_rvalid1, 1);
    check("wr_rd_rdata1", out_rdata1, 16'h1234);

    // Reset in the cycle after a granted, locked read.
    do_reset();
    step(mk(1, 0, 1, 12'h010, '0), mk(0, 0, 0, '0, '0), g0, g1);
    reset_n = 1'b0;
    #1;
    check("midrst_rvalid0", out_rvalid0, 0);
    do_reset();
    step(mk(1, 0, 0, 12'h060, '0), mk(1, 0, 0, 12'h070, '0), g0, g1);
    check("midrst_first_gnt0", g0, 1);
    step(mk(1, 0, 0, 12'h062, '0), mk(1, 0, 0, 12'h070, '0), g0, g1);
    check("midrst_unlocked_gnt1", g1, 1);

    // Randomized traffic against the model.
    do_reset();
    cur[0] = mk(0, 0, 0, '0, '0);
    cur[1] = mk(0, 0, 0, '0, '0);
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!cur[p].req) begin
          cur[p].req   = ($urandom_range(0, 9) < 6);
          cur[p].we    = 1'($urandom_range(0, 1));
          cur[p].addr  = 12'($urandom_range(0, 4095));
          cur[p].wdata = 16'($urandom);
        end
        cur[p].lock = ($urandom_range(0, 3) == 0);
      end
      step(cur[0], cur[1], g0, g1);
      if (g0) cur[0].req = 1'b0;
      if (g1) cur[1].req = 1'b0;
    end

`ifdef DMEM_ARB_STATS_EN
    // Stall/grant counters, clear, and saturation.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(mk(1, 0, 1, 12'h080, '0), mk(1, 0, 0, 12'h090, '0), g0, g1);
    end
    check("stats_stall1", out_stall_cnt1, 16'd5);
    check("stats_stall0", out_stall_cnt0, 16'd0);
    check("stats_gnt", out_gnt_cnt, 16'd5);
    in_stats_clr = 1'b1;
    step(mk(0, 0, 1, 12'h080, '0), mk(1, 0, 0, 12'h090, '0), g0, g1);
    in_stats_clr = 1'b0;
    check("stats_clr_stall1", out_stall_cnt1, 16'd0);
    check("stats_clr_gnt", out_gnt_cnt, 16'd0);
    repeat (70000) @(negedge clock);
    check("stats_sat_stall1", out_stall_cnt1, 16'hFFFF);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
